// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, op classes, immediate formats and
// the decoded-instruction record held by decode_stage.
package decode_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
    OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM, OP_ILLEGAL
  } op_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    op_e             op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [XLEN-1:0] imm;
    logic            we;
    logic            illegal;
  } dec_t;

  // Every valid opcode ends in 2'b11, so compressed encodings fall to default.
  function automatic op_e op_class(input logic [6:0] opc);
    op_e op;
    case (opc)
      OPC_LUI:    op = OP_LUI;
      OPC_AUIPC:  op = OP_AUIPC;
      OPC_JAL:    op = OP_JAL;
      OPC_JALR:   op = OP_JALR;
      OPC_BRANCH: op = OP_BRANCH;
      OPC_LOAD:   op = OP_LOAD;
      OPC_STORE:  op = OP_STORE;
      OPC_OPIMM:  op = OP_OPIMM;
      OPC_OP:     op = OP_OP;
      OPC_FENCE:  op = OP_FENCE;
      OPC_SYSTEM: op = OP_SYSTEM;
      default:    op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  function automatic fmt_e op_fmt(input op_e op);
    fmt_e f;
    case (op)
      OP_LUI, OP_AUIPC:                                f = FMT_U;
      OP_JAL:                                          f = FMT_J;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM: f = FMT_I;
      OP_BRANCH:                                       f = FMT_B;
      OP_STORE:                                        f = FMT_S;
      default:                                         f = FMT_R;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode valid/ready channel carrying the instruction word and its PC.
interface decode_if;
  import decode_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;

  modport master (output in_valid, in_instr, in_pc, input in_ready);
  modport slave  (input in_valid, in_instr, in_pc, output in_ready);
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: instruction bits [31:7] + format -> XLEN immediate.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:7]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives the register file read port on accept and holds one
// decoded instruction. Define DECODE_SCOREBOARD_EN for the RAW/WAW hazard scoreboard.
module decode_stage
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  decode_if.slave         fetch,
  output logic            rf_rd,
  output logic [RW-1:0]   rf_selrd1,
  output logic [RW-1:0]   rf_selrd2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output op_e             out_op,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [RW-1:0]   out_rd,
  output logic [RW-1:0]   out_rs1,
  output logic [RW-1:0]   out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_we,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic            flush
);
  logic [ILEN-1:0] instr;
  op_e             op;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  logic            we, hazard, accept;
  dec_t            dec, held;

  assign instr = fetch.in_instr;
  assign op    = op_class(instr[6:0]);
  assign fmt   = op_fmt(op);

  imm_gen u_imm (.instr(instr[31:7]), .fmt(fmt), .imm(imm));

  always_comb begin
    we = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP:
        we = (instr[11:7] != '0);
      default: we = 1'b0;
    endcase
  end

  always_comb begin
    dec          = '0;
    dec.pc       = fetch.in_pc;
    dec.op       = op;
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.imm      = imm;
    dec.we       = we;
    dec.illegal  = (op == OP_ILLEGAL);
  end

  assign fetch.in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept         = fetch.in_valid & fetch.in_ready;

  // Read port is addressed straight from the fetched word; strobe only on accept
  // so the register file outputs hold while the stage is stalled.
  assign rf_rd     = accept;
  assign rf_selrd1 = instr[19:15];
  assign rf_selrd2 = instr[24:20];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (flush | out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [NREG-1:0] busy, busy_nxt;
  logic            rs1_used, rs2_used;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (op)
      OP_JALR, OP_LOAD, OP_OPIMM: rs1_used = 1'b1;
      OP_BRANCH, OP_STORE, OP_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered busy only: a writeback in this cycle releases the stall next cycle.
  assign hazard = (rs1_used & busy[instr[19:15]]) |
                  (rs2_used & busy[instr[24:20]]) |
                  (we       & busy[instr[11:7]]);

  // Later assignments win: a same-cycle accept re-sets a bit that wb clears.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)                    busy_nxt[wb_rd]        = 1'b0;
    if (flush & out_valid & held.we) busy_nxt[held.rd]      = 1'b0;
    if (accept & we)                 busy_nxt[instr[11:7]]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd};
  assign hazard    = 1'b0;
`endif

  assign out_pc       = held.pc;
  assign out_op       = held.op;
  assign out_funct3   = held.funct3;
  assign out_funct7b5 = held.funct7b5;
  assign out_rd       = held.rd;
  assign out_rs1      = held.rs1;
  assign out_rs2      = held.rs2;
  assign out_imm      = held.imm;
  assign out_we       = held.we;
  assign out_illegal  = held.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, hand-written corner sequences,
// and a randomized run against an instruction-level reference model.
module tb_decode_stage;
  import decode_pkg::*;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        rf_rd, out_valid, out_funct7b5, out_we, out_illegal;
  logic [4:0]  rf_selrd1, rf_selrd2, out_rd, out_rs1, out_rs2;
  logic [31:0] out_pc, out_imm;
  logic [2:0]  out_funct3;
  op_e         out_op;
  int          checks = 0, failures = 0;

  decode_if fif();

  decode_stage dut (
    .clk(clk), .rst(rst), .fetch(fif),
    .rf_rd(rf_rd), .rf_selrd1(rf_selrd1), .rf_selrd2(rf_selrd2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_we(out_we),
    .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        we, ill, rs1u, rs2u;
  } mdl_t;

  typedef struct {
    logic [31:0] instr;
    op_e         op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        we, ill;
  } vec_t;

  // reference model state
  bit          mv;
  mdl_t        mh;
  logic [31:0] mpc;
  bit [31:0]   mbusy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Instruction-level decode from the ISA rules, immediates via integer arithmetic.
  function automatic mdl_t ref_dec(input logic [31:0] i);
    mdl_t m;
    int   si, sg, imm_i, imm_s, imm_b, imm_j;
    m      = '0;
    si     = $signed(i);
    sg     = si >>> 31;
    imm_i  = si >>> 20;
    imm_s  = (si >>> 25) * 32 + int'(i[11:7]);
    imm_b  = sg * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    imm_j  = sg * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    m.f3   = i[14:12];
    m.f7b5 = i[30];
    m.rd   = i[11:7];
    m.rs1  = i[19:15];
    m.rs2  = i[24:20];
    m.op   = OP_ILLEGAL;
    m.ill  = 1'b1;
    if (i[1:0] == 2'b11) begin
      m.ill = 1'b0;
      case (i[6:0])
        7'h37: begin m.op = OP_LUI;    m.imm = i & 32'hFFFFF000; m.we = 1; end
        7'h17: begin m.op = OP_AUIPC;  m.imm = i & 32'hFFFFF000; m.we = 1; end
        7'h6F: begin m.op = OP_JAL;    m.imm = imm_j; m.we = 1; end
        7'h67: begin m.op = OP_JALR;   m.imm = imm_i; m.we = 1; m.rs1u = 1; end
        7'h63: begin m.op = OP_BRANCH; m.imm = imm_b; m.rs1u = 1; m.rs2u = 1; end
        7'h03: begin m.op = OP_LOAD;   m.imm = imm_i; m.we = 1; m.rs1u = 1; end
        7'h23: begin m.op = OP_STORE;  m.imm = imm_s; m.rs1u = 1; m.rs2u = 1; end
        7'h13: begin m.op = OP_OPIMM;  m.imm = imm_i; m.we = 1; m.rs1u = 1; end
        7'h33: begin m.op = OP_OP;     m.we = 1; m.rs1u = 1; m.rs2u = 1; end
        7'h0F: begin m.op = OP_FENCE;  m.imm = imm_i; end
        7'h73: begin m.op = OP_SYSTEM; m.imm = imm_i; end
        default: m.ill = 1'b1;
      endcase
    end
    m.we = m.we && (m.rd != 0);
    return m;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] im;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    im  = 12'($urandom);
    case ($urandom_range(0, 9))
      0: return {im, rs1, 3'($urandom), rd, 7'h13};
      1: return {1'b0, 1'($urandom), 5'b0, rs2, rs1, 3'($urandom), rd, 7'h33};
      2: return {im, rs1, 3'b010, rd, 7'h03};
      3: return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
      4: return {7'($urandom), rs2, rs1, 3'($urandom), 5'($urandom), 7'h63};
      5: return {20'($urandom), rd, 7'h37};
      6: return {20'($urandom), rd, 7'h17};
      7: return {20'($urandom), rd, 7'h6F};
      8: return {im, rs1, 3'b000, rd, 7'h67};
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    fif.in_valid = 1'b0; fif.in_instr = '0; fif.in_pc = '0;
    out_ready = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    mv = 0; mh = '0; mpc = '0; mbusy = '0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  vec_t        tv[15];
  logic [31:0] cur, cur_pc;
  mdl_t        d;
  bit          haz, er, acc;
  bit [31:0]   nb;

  initial begin
    tv[0]  = '{32'h00700293, OP_OPIMM,  5'd5,  5'd0,  5'd7,  32'h00000007, 1'b1, 1'b0};
    tv[1]  = '{32'hFE000EE3, OP_BRANCH, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b0};
    tv[2]  = '{32'h00000000, OP_ILLEGAL,5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1};
    tv[3]  = '{32'h123450B7, OP_LUI,    5'd1,  5'd8,  5'd3,  32'h12345000, 1'b1, 1'b0};
    tv[4]  = '{32'hFE21AC23, OP_STORE,  5'd24, 5'd3,  5'd2,  32'hFFFFFFF8, 1'b0, 1'b0};
    tv[5]  = '{32'h008000EF, OP_JAL,    5'd1,  5'd0,  5'd8,  32'h00000008, 1'b1, 1'b0};
    tv[6]  = '{32'h00528333, OP_OP,     5'd6,  5'd5,  5'd5,  32'h00000000, 1'b1, 1'b0};
    tv[7]  = '{32'h00208033, OP_OP,     5'd0,  5'd1,  5'd2,  32'h00000000, 1'b0, 1'b0};
    tv[8]  = '{32'h00000001, OP_ILLEGAL,5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1};
    tv[9]  = '{32'h0000047F, OP_ILLEGAL,5'd8,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1};
    tv[10] = '{32'h00412483, OP_LOAD,   5'd9,  5'd2,  5'd4,  32'h00000004, 1'b1, 1'b0};
    tv[11] = '{32'h0FF0000F, OP_FENCE,  5'd0,  5'd0,  5'd31, 32'h000000FF, 1'b0, 1'b0};
    tv[12] = '{32'hFFFFF197, OP_AUIPC,  5'd3,  5'd31, 5'd31, 32'hFFFFF000, 1'b1, 1'b0};
    tv[13] = '{32'h00000073, OP_SYSTEM, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0};
    tv[14] = '{32'hFFF100E7, OP_JALR,   5'd1,  5'd2,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b0};

    // reset state
    fif.in_valid = 1'b0; fif.in_instr = '0; fif.in_pc = '0;
    #2;
    chk("rst_state", {fif.in_ready, rf_rd, out_valid, out_op, out_funct3, out_funct7b5, out_rd,
                      out_rs1, out_rs2, out_imm, out_we, out_illegal, out_pc}, '0);
    edge1(); rst = 1'b0; #1;
    chk("rst_ready", fif.in_ready, 1'b1);

    // vector table: accept, single rf_rd pulse, decoded fields, drain
    foreach (tv[k]) begin
      do_reset();
      fif.in_valid = 1'b1; fif.in_instr = tv[k].instr; fif.in_pc = 32'h100 + k * 4; out_ready = 1'b1;
      #1;
      chk($sformatf("tv%0d_accept", k), {fif.in_ready, rf_rd}, 2'b11);
      edge1(); fif.in_valid = 1'b0; #1;
      chk($sformatf("tv%0d_fields", k),
          {out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm, out_we, out_illegal, out_pc, rf_rd},
          {1'b1, tv[k].op, tv[k].rd, tv[k].rs1, tv[k].rs2, tv[k].imm, tv[k].we, tv[k].ill,
           32'h100 + 32'(k) * 4, 1'b0});
      edge1();
      chk($sformatf("tv%0d_drain", k), out_valid, 1'b0);
    end

    // RAW: add x6,x5,x5 right after addi x5
    do_reset();
    out_ready = 1'b1; fif.in_valid = 1'b1; fif.in_instr = 32'h00700293; #1;
    chk("raw_prod", {fif.in_ready, rf_rd}, 2'b11);
    edge1(); fif.in_instr = 32'h00528333; #1;
    repeat (3) begin
      chk("raw_stall", {fif.in_ready, rf_rd}, SB ? 2'b00 : 2'b11);
      edge1();
    end
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    chk("raw_wb_cycle", fif.in_ready, !SB);
    edge1(); wb_valid = 1'b0; #1;
    chk("raw_release", {fif.in_ready, rf_rd}, 2'b11);
    edge1(); fif.in_valid = 1'b0; #1;
    chk("raw_issue", {out_valid, out_op, out_rd}, {1'b1, OP_OP, 5'd6});

    // backpressure: out_ready low for 3 cycles, then release
    do_reset();
    out_ready = 1'b1; fif.in_valid = 1'b1; fif.in_instr = 32'h00700293;
    edge1(); out_ready = 1'b0; fif.in_instr = 32'h00000073; #1;
    repeat (3) begin
      chk("bp_hold", {fif.in_ready, rf_rd, out_valid, out_op, out_rd, out_imm, out_we},
          {1'b0, 1'b0, 1'b1, OP_OPIMM, 5'd5, 32'd7, 1'b1});
      edge1();
    end
    out_ready = 1'b1; #1;
    chk("bp_release", {fif.in_ready, rf_rd}, 2'b11);
    edge1(); fif.in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("bp_next", {out_valid, out_op}, {1'b1, OP_SYSTEM});
    rst = 1'b1; #1;
    chk("rst_async", {out_valid, out_op, fif.in_ready}, '0);

    // illegal word with nonzero rd field must not mark that register busy
    do_reset();
    out_ready = 1'b1; fif.in_valid = 1'b1; fif.in_instr = 32'h0000047F;
    edge1(); fif.in_instr = 32'h00040093; #1;
    chk("ill_nobusy", {fif.in_ready, rf_rd, out_illegal, out_we}, 4'b1110);

    // flush while holding lw x9; reader of x9 then proceeds
    do_reset();
    fif.in_valid = 1'b1; fif.in_instr = 32'h00412483;
    edge1(); fif.in_instr = 32'h00048093; flush = 1'b1; #1;
    chk("flush_noacc", {fif.in_ready, rf_rd}, 2'b00);
    edge1(); flush = 1'b0; #1;
    chk("flush_drop", out_valid, 1'b0);
    chk("flush_clear", {fif.in_ready, rf_rd}, 2'b11);
    edge1(); fif.in_valid = 1'b0; #1;
    chk("flush_reader", {out_valid, out_rs1, out_rd}, {1'b1, 5'd9, 5'd1});

    // randomized run against the reference model
    do_reset();
    cur = gen_instr(); cur_pc = $urandom;
    for (int c = 0; c < 600; c++) begin
      fif.in_valid = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 7);
      wb_valid     = ($urandom_range(0, 9) < 3);
      wb_rd        = 5'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 19) == 0);
      fif.in_instr = cur; fif.in_pc = cur_pc;
      #1;
      d   = ref_dec(cur);
      haz = SB && ((d.rs1u && mbusy[d.rs1]) || (d.rs2u && mbusy[d.rs2]) || (d.we && mbusy[d.rd]));
      er  = !flush && !haz && (!mv || out_ready);
      acc = fif.in_valid && er;
      chk("rnd_in", {fif.in_ready, rf_rd, rf_selrd1, rf_selrd2}, {er, acc, cur[19:15], cur[24:20]});
      nb = mbusy;
      if (wb_valid) nb[wb_rd] = 1'b0;
      if (flush && mv && mh.we) nb[mh.rd] = 1'b0;
      if (acc && d.we) nb[d.rd] = 1'b1;
      nb[0] = 1'b0;
      mbusy = nb;
      if (acc) begin mv = 1; mh = d; mpc = cur_pc; end
      else if (flush || out_ready) mv = 0;
      if (acc || !fif.in_valid) begin cur = gen_instr(); cur_pc = $urandom; end
      edge1();
      chk("rnd_out",
          {out_valid, out_op, out_funct3, out_funct7b5, out_rd, out_rs1, out_rs2, out_imm,
           out_we, out_illegal, out_pc},
          {mv, mh.op, mh.f3, mh.f7b5, mh.rd, mh.rs1, mh.rs2, mh.imm, mh.we, mh.ill, mpc});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
